mod31_down_timer: RTL and testbench

- Sequential modulo-31 down-counter/timer; counterpart of the mod-31 incrementer next-state logic.
- Counts 30→0 and wraps 0→30, never 31.
- Sits beside the up-counter in the SoC timing path.
- Provides one-shot, auto-reload and free-running wrap modes, with registered done and borrow strobes.

---
 rtl/mod31_down_timer.sv | 152 +++++++++++++++
 tb/tb_mod31_down_timer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod31_down_timer.sv
// ============================================================================
// Module   : mod31_down_timer
// Brief    : Modulo-31 down-counter/timer with one-shot, auto-reload and
//            free-run wrap modes; optional sticky irq via MOD31_TIMER_IRQ_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod31_down_timer #(
  parameter int RESET_VAL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  input  logic [1:0] mode,
  output logic [4:0] count,
  output logic       busy,
  output logic       done,
  output logic       borrow
`ifdef MOD31_TIMER_IRQ_EN
  ,
  input  logic       irq_clr,
  output logic       irq
`endif
);

  localparam logic       C_ST_IDLE      = 1'b0;
  localparam logic       C_ST_RUN       = 1'b1;
  localparam logic [1:0] C_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] C_MODE_RELOAD  = 2'b01;
  localparam logic [1:0] C_MODE_FREE    = 2'b10;
  localparam logic [4:0] C_MAX          = 5'd30;
  localparam logic [4:0] C_RESET_CNT    = (RESET_VAL >= 30) ? C_MAX : 5'(RESET_VAL);

  logic       r_state, w_state_nxt;
  logic [4:0] r_count, w_count_nxt;
  logic [4:0] r_reload, w_reload_nxt;
  logic [1:0] r_mode, w_mode_nxt;
  logic       r_done, w_done_nxt;
  logic       r_borrow, w_borrow_nxt;
  logic [4:0] w_load_clamped;
  logic [1:0] w_mode_in;

  assign w_load_clamped = (load_val == 5'd31) ? C_MAX : load_val;
  assign w_mode_in      = (mode == 2'b11) ? C_MODE_ONESHOT : mode;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_done_nxt   = 1'b0;
    w_borrow_nxt = 1'b0;
    if (load) begin
      w_count_nxt  = w_load_clamped;
      w_reload_nxt = w_load_clamped;
      w_state_nxt  = C_ST_IDLE;
    end else if (stop) begin
      w_state_nxt = C_ST_IDLE;
    end else if (r_state == C_ST_IDLE) begin
      if (start) begin
        w_mode_nxt = w_mode_in;
        if (r_count != 5'd0 || w_mode_in == C_MODE_FREE) begin
          w_state_nxt = C_ST_RUN;
        end else begin
          // Starting from zero counts as an immediate expiry.
          w_done_nxt = 1'b1;
          if (w_mode_in == C_MODE_RELOAD) begin
            w_state_nxt = C_ST_RUN;
            w_count_nxt = r_reload;
          end
        end
      end
    end else if (tick) begin
      case (r_mode)
        C_MODE_FREE: begin
          if (r_count == 5'd0) begin
            w_count_nxt  = C_MAX;
            w_borrow_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count - 5'd1;
          end
        end
        C_MODE_RELOAD: begin
          if (r_count == 5'd0) begin
            w_count_nxt = r_reload;
            w_done_nxt  = (r_reload == 5'd0);
          end else begin
            w_count_nxt = r_count - 5'd1;
            w_done_nxt  = (r_count == 5'd1);
          end
        end
        default: begin
          if (r_count <= 5'd1) begin
            w_count_nxt = 5'd0;
            w_done_nxt  = (r_count == 5'd1);
            w_state_nxt = C_ST_IDLE;
          end else begin
            w_count_nxt = r_count - 5'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= C_ST_IDLE;
      r_count  <= C_RESET_CNT;
      r_reload <= C_RESET_CNT;
      r_mode   <= C_MODE_ONESHOT;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_mode   <= w_mode_nxt;
      r_done   <= w_done_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  assign count  = r_count;
  assign busy   = (r_state == C_ST_RUN);
  assign done   = r_done;
  assign borrow = r_borrow;

`ifdef MOD31_TIMER_IRQ_EN
  logic r_irq;

  // A visible strobe sets the flag; set beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else if (r_done || r_borrow) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod31_down_timer.sv
// ============================================================================
// Module   : tb_mod31_down_timer
// Brief    : Self-checking bench for mod31_down_timer (vectors + random model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mod31_down_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = 5'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [4:0] count;
  logic       busy;
  logic       done;
  logic       borrow;
`ifdef MOD31_TIMER_IRQ_EN
  logic       irq_clr = 1'b0;
  logic       irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt, m_rel, m_mode;
  bit m_run, m_done, m_borrow, m_irq;

  typedef struct {
    bit ld; int lv; bit sa; bit sp; bit tk; int md;
    int cnt; bit bsy; bit dn; bit br;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mod31_down_timer #(.RESET_VAL(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .mode     (mode),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .borrow   (borrow)
`ifdef MOD31_TIMER_IRQ_EN
    ,
    .irq_clr  (irq_clr),
    .irq      (irq)
`endif
  );

  function automatic vec_t v(bit ld, int lv, bit sa, bit sp, bit tk, int md,
                             int cnt, bit bsy, bit dn, bit br);
    vec_t r;
    r.ld = ld; r.lv = lv; r.sa = sa; r.sp = sp; r.tk = tk; r.md = md;
    r.cnt = cnt; r.bsy = bsy; r.dn = dn; r.br = br;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_mode = 0;
    m_run = 0; m_done = 0; m_borrow = 0; m_irq = 0;
  endtask

  // Timer behaviour expressed directly from the rules, integer arithmetic.
  task automatic model_step(input bit ld, input int lv, input bit sa, input bit sp,
                            input bit tk, input int md, input bit clr);
    if (m_done || m_borrow) m_irq = 1;
    else if (clr) m_irq = 0;
    m_done = 0;
    m_borrow = 0;
    if (ld) begin
      m_cnt = (lv == 31) ? 30 : lv;
      m_rel = m_cnt;
      m_run = 0;
    end else if (sp) begin
      m_run = 0;
    end else if (!m_run) begin
      if (sa) begin
        m_mode = (md == 3) ? 0 : md;
        if (m_cnt != 0 || m_mode == 2) m_run = 1;
        else begin
          m_done = 1;
          if (m_mode == 1) begin m_run = 1; m_cnt = m_rel; end
        end
      end
    end else if (tk) begin
      if (m_mode == 2) begin
        if (m_cnt == 0) begin m_cnt = 30; m_borrow = 1; end
        else m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_cnt = m_rel;
        if (m_rel == 0) m_done = 1;
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1;
          if (m_mode == 0) m_run = 0;
        end
      end
    end
  endtask

  task automatic cycle(input bit ld, input int lv, input bit sa, input bit sp,
                       input bit tk, input int md, input bit clr);
    load = ld; load_val = lv[4:0]; start = sa; stop = sp; tick = tk; mode = md[1:0];
`ifdef MOD31_TIMER_IRQ_EN
    irq_clr = clr;
`endif
    model_step(ld, lv, sa, sp, tk, md, clr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int borrows;
    int dones;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset count", int'(count), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset borrow", int'(borrow), 0);
    rst_n = 1'b1;

    // One-shot from 3
    vecs.push_back(v(1, 3, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Auto-reload with period 3
    vecs.push_back(v(1, 2, 0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    // stop+tick, then load+start
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 2, 0, 0, 0));
    vecs.push_back(v(1, 7, 1, 0, 0, 0, 7, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 7, 0, 0, 0));
    // Start from zero in each mode
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 3, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 2, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 30, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 29, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 1, 28, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 28, 0, 0, 0));
    // Auto-reload with reload 0
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(v(1, 5, 0, 0, 1, 0, 5, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 5, 0, 0, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].ld, vecs[i].lv, vecs[i].sa, vecs[i].sp, vecs[i].tk, vecs[i].md, 1'b0);
      check($sformatf("vec%0d count", i), int'(count), vecs[i].cnt);
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].bsy));
      check($sformatf("vec%0d done", i), int'(done), int'(vecs[i].dn));
      check($sformatf("vec%0d borrow", i), int'(borrow), int'(vecs[i].br));
    end

    // Free-run full lap from a clamped 31
    cycle(1, 31, 0, 0, 0, 0, 0);
    check("freerun clamp", int'(count), 30);
    cycle(0, 0, 1, 0, 0, 2, 0);
    check("freerun busy", int'(busy), 1);
    borrows = 0;
    dones = 0;
    for (int k = 1; k <= 32; k++) begin
      cycle(0, 0, 0, 0, 1, 0, 0);
      check($sformatf("freerun tick%0d", k), int'(count), (k <= 30) ? 30 - k : 61 - k);
      check($sformatf("freerun borrow%0d", k), int'(borrow), (k == 31) ? 1 : 0);
      borrows += int'(borrow);
      dones += int'(done);
    end
    check("freerun borrow total", borrows, 1);
    check("freerun done total", dones, 0);

    // Asynchronous reset mid-count
    cycle(1, 8, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 1, 0, 0);
    check("pre-reset count", int'(count), 5);
    #2 rst_n = 1'b0;
    #1;
    check("async reset count", int'(count), 0);
    check("async reset busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    check("held reset done", int'(done), 0);
    rst_n = 1'b1;

`ifdef MOD31_TIMER_IRQ_EN
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("irq done", int'(done), 1);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      check($sformatf("irq sticky%0d", k), int'(irq), 1);
    end
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("irq cleared", int'(irq), 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("irq set wins", int'(irq), 1);
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(15) == 0), int'($urandom_range(31)),
            ($urandom_range(7) == 0), ($urandom_range(15) == 0),
            ($urandom_range(3) != 0), int'($urandom_range(3)),
            ($urandom_range(7) == 0));
      check($sformatf("rand%0d count", n), int'(count), m_cnt);
      check($sformatf("rand%0d busy", n), int'(busy), int'(m_run));
      check($sformatf("rand%0d done", n), int'(done), int'(m_done));
      check($sformatf("rand%0d borrow", n), int'(borrow), int'(m_borrow));
`ifdef MOD31_TIMER_IRQ_EN
      check($sformatf("rand%0d irq", n), int'(irq), int'(m_irq));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
